result_addr_gen: RTL and testbench
==================================

// Module: result_addr_gen
// PURPOSE
//  Parametrised circular-buffer address generator for the match-result store.
//  Sniffer logic writes one result per slot at wr_addr and pulses inc_addr; the host
//  drains slots at rd_addr and pulses rd_done. Tracks occupancy, full/empty and overflow,
//  with an optional overwrite-oldest mode. Sits between the match/result FSM and the result memory.
// PARAMETERS
//  ADDR_W     32            width of wr_addr/rd_addr
//  BASE_ADDR  32'h0000_0000 byte address of slot 0 (ADDR_W bits)
//  STRIDE     4             byte distance between consecutive slots (>=1)
//  NUM_SLOTS  5             number of result slots (>=2)
//  OVERWRITE  0             0: drop writes when full; 1: overwrite oldest slot when full
//  localparam IDX_W = $clog2(NUM_SLOTS), CNT_W = $clog2(NUM_SLOTS+1)
// PORTS
//  clk        in   1      system clock, rising edge
//  n_rst      in   1      asynchronous active-low reset
//  clear      in   1      synchronous flush: pointers, count and flags to reset values
//  inc_addr   in   1      1-cycle pulse: current wr slot written, advance write pointer
//  rd_done    in   1      1-cycle pulse: current rd slot consumed, advance read pointer
//  wr_addr    out  ADDR_W address for the next result write
//  rd_addr    out  ADDR_W address of the oldest unread result
//  count      out  CNT_W  occupied slots, 0..NUM_SLOTS
//  empty      out  1      count == 0
//  full       out  1      count == NUM_SLOTS
//  overflow   out  1      sticky: an inc_addr arrived while full
// BEHAVIOUR
//  - Reset (n_rst=0, async): wr_idx=rd_idx=0, count=0, overflow=0, so wr_addr=rd_addr=BASE_ADDR,
//    empty=1, full=0.
//  - wr_addr/rd_addr/count/overflow are registered. wr_addr = BASE_ADDR + wr_idx*STRIDE, computed
//    from the next index and latched on the same edge. Flags are decoded from registered count.
//  - Latency: a pulse sampled at edge k is reflected on all outputs immediately after edge k.
//  - Indices run 0..NUM_SLOTS-1 and wrap to 0 after NUM_SLOTS-1. Correct for non-power-of-2 depth.
//  - Address math is done in ADDR_W bits and truncated mod 2^ADDR_W. No saturation.
//  - Per edge, priority order: clear > (inc_addr, rd_done).
//    - clear=1: same result as reset, except it is synchronous. Pulses in the same cycle are discarded.
//  - Per edge, with w=inc_addr and r=rd_done:
//    - w only, not full: wr_idx++, count++.
//    - w only, full, OVERWRITE=0: write dropped. Pointers and count unchanged. overflow<=1.
//    - w only, full, OVERWRITE=1: wr_idx++, rd_idx++ (oldest discarded), count unchanged, overflow<=1.
//    - r only, not empty: rd_idx++, count--.
//    - r only, empty: ignored. No state change.
//    - w&r, not empty and not full: both advance, count unchanged.
//    - w&r, full: both advance, count unchanged, overflow stays as is (no drop occurs).
//    - w&r, empty: write accepted, read ignored. wr_idx++, count=1.
//  - overflow clears only on reset or clear.
//  - Reset asserted mid-operation returns to the reset state at once. Outputs are stable the
//    cycle after deassertion.
//  - Internal state: EMPTY / PARTIAL / FULL, derived from count.
//    - EMPTY->PARTIAL on an accepted write.
//    - PARTIAL->FULL when count reaches NUM_SLOTS.
//    - FULL->PARTIAL on a read.
//    - PARTIAL->EMPTY when count reaches 0.
// TESTING (BASE_ADDR=32'h1000, STRIDE=4, NUM_SLOTS=5 unless noted)
//  1. Reset, then 5 inc_addr pulses
//     -> wr_addr goes 1004,1008,100C,1010,1000; count reaches 5; full=1; rd_addr stays 1000.
//  2. Full, OVERWRITE=0, then inc_addr
//     -> wr_addr 1000 and count 5 unchanged; overflow=1 and held until clear.
//  3. Full, OVERWRITE=1, then inc_addr
//     -> wr_addr=1004, rd_addr=1004, count=5, overflow=1.
//  4. count=2, inc_addr&rd_done on the same edge
//     -> count=2, both addresses advance by 4. When empty, rd_done alone leaves all outputs unchanged.
//  5. count=3, clear&inc_addr on the same edge -> all outputs at reset values.
//     Then n_rst pulsed low mid-burst -> async return to reset values.
//  6. NUM_SLOTS=3, STRIDE=16, BASE=32'hFFFF_FFE0 -> wr_addr sequence FFFFFFF0,00000000,FFFFFFE0.
//     Checks truncation and wrap.

Source files
------------

// File: rtl/result_addr_gen_if.sv
// Handshake/status bundle between the result producer/host side and the result address generator.
// The generator owns the addresses, count and flags; the other side owns the pulses.
interface result_addr_gen_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 3
);
  logic              clear;
  logic              inc_addr;
  logic              rd_done;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;
  logic              overflow;

  modport master (
    output clear, inc_addr, rd_done,
    input  wr_addr, rd_addr, count, empty, full, overflow
  );

  modport slave (
    input  clear, inc_addr, rd_done,
    output wr_addr, rd_addr, count, empty, full, overflow
  );
endinterface

// File: rtl/result_addr_gen.sv
// Circular-buffer slot address generator for the match-result store; pulses take effect on the sampling edge.
// No backpressure: writes while full are dropped (or evict the oldest slot) and latch a sticky overflow.
module result_addr_gen #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       STRIDE    = 4,
  parameter int                NUM_SLOTS = 5,
  parameter bit                OVERWRITE = 1'b0
) (
  input logic              clk,
  input logic              n_rst,
  result_addr_gen_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_SLOTS);
  localparam int CNT_W = $clog2(NUM_SLOTS + 1);

  typedef enum logic [1:0] {ST_EMPTY, ST_PARTIAL, ST_FULL} state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  wr_idx, rd_idx, wr_idx_nxt, rd_idx_nxt;
  logic [CNT_W-1:0]  count_q, count_nxt;
  logic              overflow_q, overflow_nxt;
  logic [ADDR_W-1:0] wr_addr_q, rd_addr_q;

  // Explicit wrap keeps non-power-of-2 depths correct.
  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(NUM_SLOTS - 1)) ? '0 : idx + IDX_W'(1);
  endfunction

  function automatic logic [ADDR_W-1:0] slot_addr(input logic [IDX_W-1:0] idx);
    return BASE_ADDR + ADDR_W'(idx) * ADDR_W'(STRIDE);
  endfunction

  always_comb begin
    state_nxt    = state;
    wr_idx_nxt   = wr_idx;
    rd_idx_nxt   = rd_idx;
    count_nxt    = count_q;
    overflow_nxt = overflow_q;

    if (bus.clear) begin
      state_nxt    = ST_EMPTY;
      wr_idx_nxt   = '0;
      rd_idx_nxt   = '0;
      count_nxt    = '0;
      overflow_nxt = 1'b0;
    end else if (bus.inc_addr && !bus.rd_done) begin
      if (state != ST_FULL) begin
        wr_idx_nxt = idx_inc(wr_idx);
        count_nxt  = count_q + CNT_W'(1);
        state_nxt  = (count_q == CNT_W'(NUM_SLOTS - 1)) ? ST_FULL : ST_PARTIAL;
      end else begin
        overflow_nxt = 1'b1;
        if (OVERWRITE) begin
          wr_idx_nxt = idx_inc(wr_idx);
          rd_idx_nxt = idx_inc(rd_idx);
        end
      end
    end else if (bus.rd_done && !bus.inc_addr) begin
      if (state != ST_EMPTY) begin
        rd_idx_nxt = idx_inc(rd_idx);
        count_nxt  = count_q - CNT_W'(1);
        state_nxt  = (count_q == CNT_W'(1)) ? ST_EMPTY : ST_PARTIAL;
      end
    end else if (bus.rd_done && bus.inc_addr) begin
      // On empty the read has nothing to consume, so only the write lands.
      wr_idx_nxt = idx_inc(wr_idx);
      if (state == ST_EMPTY) begin
        count_nxt = CNT_W'(1);
        state_nxt = ST_PARTIAL;
      end else begin
        rd_idx_nxt = idx_inc(rd_idx);
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= ST_EMPTY;
      wr_idx     <= '0;
      rd_idx     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      wr_addr_q  <= BASE_ADDR;
      rd_addr_q  <= BASE_ADDR;
    end else begin
      state      <= state_nxt;
      wr_idx     <= wr_idx_nxt;
      rd_idx     <= rd_idx_nxt;
      count_q    <= count_nxt;
      overflow_q <= overflow_nxt;
      wr_addr_q  <= slot_addr(wr_idx_nxt);
      rd_addr_q  <= slot_addr(rd_idx_nxt);
    end
  end

  assign bus.wr_addr  = wr_addr_q;
  assign bus.rd_addr  = rd_addr_q;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
  assign bus.empty    = (count_q == '0);
  assign bus.full     = (count_q == CNT_W'(NUM_SLOTS));
endmodule

// File: tb/tb_result_addr_gen.sv
// Directed bench for result_addr_gen: drop mode, overwrite mode and a small wrapping instance.
module tb_result_addr_gen;
  logic clk   = 1'b0;
  logic n_rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  result_addr_gen_if #(.ADDR_W(32), .CNT_W(3)) bus_a ();
  result_addr_gen_if #(.ADDR_W(32), .CNT_W(3)) bus_b ();
  result_addr_gen_if #(.ADDR_W(32), .CNT_W(2)) bus_c ();

  result_addr_gen #(.ADDR_W(32), .BASE_ADDR(32'h1000), .STRIDE(4), .NUM_SLOTS(5), .OVERWRITE(1'b0))
    dut_a (.clk(clk), .n_rst(n_rst), .bus(bus_a));
  result_addr_gen #(.ADDR_W(32), .BASE_ADDR(32'h1000), .STRIDE(4), .NUM_SLOTS(5), .OVERWRITE(1'b1))
    dut_b (.clk(clk), .n_rst(n_rst), .bus(bus_b));
  result_addr_gen #(.ADDR_W(32), .BASE_ADDR(32'hFFFF_FFE0), .STRIDE(16), .NUM_SLOTS(3), .OVERWRITE(1'b0))
    dut_c (.clk(clk), .n_rst(n_rst), .bus(bus_c));

  // Observed tuple: {wr_addr, rd_addr, count, empty, full, overflow}
  wire [69:0] obs_a = {bus_a.wr_addr, bus_a.rd_addr, bus_a.count, bus_a.empty, bus_a.full, bus_a.overflow};
  wire [69:0] obs_b = {bus_b.wr_addr, bus_b.rd_addr, bus_b.count, bus_b.empty, bus_b.full, bus_b.overflow};
  wire [68:0] obs_c = {bus_c.wr_addr, bus_c.rd_addr, bus_c.count, bus_c.empty, bus_c.full, bus_c.overflow};

  task automatic step_a(input logic c, input logic w, input logic r);
    bus_a.clear = c; bus_a.inc_addr = w; bus_a.rd_done = r;
    @(posedge clk); #1;
    bus_a.clear = 1'b0; bus_a.inc_addr = 1'b0; bus_a.rd_done = 1'b0;
  endtask

  task automatic step_b(input logic c, input logic w, input logic r);
    bus_b.clear = c; bus_b.inc_addr = w; bus_b.rd_done = r;
    @(posedge clk); #1;
    bus_b.clear = 1'b0; bus_b.inc_addr = 1'b0; bus_b.rd_done = 1'b0;
  endtask

  task automatic step_c(input logic c, input logic w, input logic r);
    bus_c.clear = c; bus_c.inc_addr = w; bus_c.rd_done = r;
    @(posedge clk); #1;
    bus_c.clear = 1'b0; bus_c.inc_addr = 1'b0; bus_c.rd_done = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (obs_a !== {32'h1000, 32'h1000, 3'd0, 3'b100}) begin
      errors++; $display("FAIL reset_a actual=%h required=%h", obs_a, {32'h1000, 32'h1000, 3'd0, 3'b100});
    end
    checks++;
    if (obs_c !== {32'hFFFF_FFE0, 32'hFFFF_FFE0, 2'd0, 3'b100}) begin
      errors++; $display("FAIL reset_c actual=%h required=%h", obs_c, {32'hFFFF_FFE0, 32'hFFFF_FFE0, 2'd0, 3'b100});
    end
  endtask

  task automatic test_fill();
    logic [31:0] exp_wr [5] = '{32'h1004, 32'h1008, 32'h100C, 32'h1010, 32'h1000};
    logic [69:0] exp_t;
    for (int i = 0; i < 5; i++) begin
      step_a(1'b0, 1'b1, 1'b0);
      exp_t = {exp_wr[i], 32'h1000, 3'(i + 1), 1'b0, (i == 4), 1'b0};
      checks++;
      if (obs_a !== exp_t) begin
        errors++; $display("FAIL fill_%0d actual=%h required=%h", i, obs_a, exp_t);
      end
    end
  endtask

  task automatic test_overflow_drop();
    step_a(1'b0, 1'b1, 1'b0);
    checks++;
    if (obs_a !== {32'h1000, 32'h1000, 3'd5, 3'b011}) begin
      errors++; $display("FAIL drop_when_full actual=%h required=%h", obs_a, {32'h1000, 32'h1000, 3'd5, 3'b011});
    end
    step_a(1'b0, 1'b0, 1'b1);
    checks++;
    if (obs_a !== {32'h1000, 32'h1004, 3'd4, 3'b001}) begin
      errors++; $display("FAIL overflow_sticky actual=%h required=%h", obs_a, {32'h1000, 32'h1004, 3'd4, 3'b001});
    end
    step_a(1'b1, 1'b0, 1'b0);
    checks++;
    if (obs_a !== {32'h1000, 32'h1000, 3'd0, 3'b100}) begin
      errors++; $display("FAIL clear_overflow actual=%h required=%h", obs_a, {32'h1000, 32'h1000, 3'd0, 3'b100});
    end
  endtask

  task automatic test_overwrite();
    for (int i = 0; i < 5; i++) step_b(1'b0, 1'b1, 1'b0);
    checks++;
    if (obs_b !== {32'h1000, 32'h1000, 3'd5, 3'b010}) begin
      errors++; $display("FAIL ovw_full actual=%h required=%h", obs_b, {32'h1000, 32'h1000, 3'd5, 3'b010});
    end
    step_b(1'b0, 1'b1, 1'b0);
    checks++;
    if (obs_b !== {32'h1004, 32'h1004, 3'd5, 3'b011}) begin
      errors++; $display("FAIL ovw_evict actual=%h required=%h", obs_b, {32'h1004, 32'h1004, 3'd5, 3'b011});
    end
  endtask

  task automatic test_back_to_back();
    step_a(1'b0, 1'b1, 1'b0);
    step_a(1'b0, 1'b1, 1'b0);
    step_a(1'b0, 1'b1, 1'b1);
    checks++;
    if (obs_a !== {32'h100C, 32'h1004, 3'd2, 3'b000}) begin
      errors++; $display("FAIL wr_rd_partial actual=%h required=%h", obs_a, {32'h100C, 32'h1004, 3'd2, 3'b000});
    end
    step_a(1'b0, 1'b0, 1'b1);
    step_a(1'b0, 1'b0, 1'b1);
    checks++;
    if (obs_a !== {32'h100C, 32'h100C, 3'd0, 3'b100}) begin
      errors++; $display("FAIL drain actual=%h required=%h", obs_a, {32'h100C, 32'h100C, 3'd0, 3'b100});
    end
    step_a(1'b0, 1'b0, 1'b1);
    checks++;
    if (obs_a !== {32'h100C, 32'h100C, 3'd0, 3'b100}) begin
      errors++; $display("FAIL rd_empty actual=%h required=%h", obs_a, {32'h100C, 32'h100C, 3'd0, 3'b100});
    end
    step_a(1'b0, 1'b1, 1'b1);
    checks++;
    if (obs_a !== {32'h1010, 32'h100C, 3'd1, 3'b000}) begin
      errors++; $display("FAIL wr_rd_empty actual=%h required=%h", obs_a, {32'h1010, 32'h100C, 3'd1, 3'b000});
    end
    step_a(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step_a(1'b0, 1'b1, 1'b0);
    step_a(1'b0, 1'b1, 1'b1);
    checks++;
    if (obs_a !== {32'h1004, 32'h1004, 3'd5, 3'b010}) begin
      errors++; $display("FAIL wr_rd_full actual=%h required=%h", obs_a, {32'h1004, 32'h1004, 3'd5, 3'b010});
    end
  endtask

  task automatic test_clear_and_reset();
    step_a(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step_a(1'b0, 1'b1, 1'b0);
    checks++;
    if (obs_a !== {32'h100C, 32'h1000, 3'd3, 3'b000}) begin
      errors++; $display("FAIL pre_clear actual=%h required=%h", obs_a, {32'h100C, 32'h1000, 3'd3, 3'b000});
    end
    step_a(1'b1, 1'b1, 1'b0);
    checks++;
    if (obs_a !== {32'h1000, 32'h1000, 3'd0, 3'b100}) begin
      errors++; $display("FAIL clear_wins actual=%h required=%h", obs_a, {32'h1000, 32'h1000, 3'd0, 3'b100});
    end
    step_a(1'b0, 1'b1, 1'b0);
    step_a(1'b0, 1'b1, 1'b0);
    bus_a.inc_addr = 1'b1;
    #2 n_rst = 1'b0;
    #1;
    checks++;
    if (obs_a !== {32'h1000, 32'h1000, 3'd0, 3'b100}) begin
      errors++; $display("FAIL async_reset_a actual=%h required=%h", obs_a, {32'h1000, 32'h1000, 3'd0, 3'b100});
    end
    checks++;
    if (obs_b !== {32'h1000, 32'h1000, 3'd0, 3'b100}) begin
      errors++; $display("FAIL async_reset_b actual=%h required=%h", obs_b, {32'h1000, 32'h1000, 3'd0, 3'b100});
    end
    @(posedge clk); #1;
    checks++;
    if (obs_a !== {32'h1000, 32'h1000, 3'd0, 3'b100}) begin
      errors++; $display("FAIL held_in_reset actual=%h required=%h", obs_a, {32'h1000, 32'h1000, 3'd0, 3'b100});
    end
    bus_a.inc_addr = 1'b0;
    @(negedge clk) n_rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (obs_a !== {32'h1000, 32'h1000, 3'd0, 3'b100}) begin
      errors++; $display("FAIL after_release actual=%h required=%h", obs_a, {32'h1000, 32'h1000, 3'd0, 3'b100});
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_wr [3] = '{32'hFFFF_FFF0, 32'h0000_0000, 32'hFFFF_FFE0};
    logic [68:0] exp_t;
    for (int i = 0; i < 3; i++) begin
      step_c(1'b0, 1'b1, 1'b0);
      exp_t = {exp_wr[i], 32'hFFFF_FFE0, 2'(i + 1), 1'b0, (i == 2), 1'b0};
      checks++;
      if (obs_c !== exp_t) begin
        errors++; $display("FAIL wrap_%0d actual=%h required=%h", i, obs_c, exp_t);
      end
    end
    step_c(1'b0, 1'b0, 1'b1);
    checks++;
    if (obs_c !== {32'hFFFF_FFE0, 32'hFFFF_FFF0, 2'd2, 3'b000}) begin
      errors++; $display("FAIL wrap_rd actual=%h required=%h", obs_c, {32'hFFFF_FFE0, 32'hFFFF_FFF0, 2'd2, 3'b000});
    end
  endtask

  initial begin
    bus_a.clear = 1'b0; bus_a.inc_addr = 1'b0; bus_a.rd_done = 1'b0;
    bus_b.clear = 1'b0; bus_b.inc_addr = 1'b0; bus_b.rd_done = 1'b0;
    bus_c.clear = 1'b0; bus_c.inc_addr = 1'b0; bus_c.rd_done = 1'b0;
    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) n_rst = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_fill();
    test_overflow_drop();
    test_overwrite();
    test_back_to_back();
    test_clear_and_reset();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
